mac_result_fifo: RTL

MAC_RESULT_FIFO -- requirements
Module: mac_result_fifo

---
 rtl/mac_result_fifo.sv | 79 +++++++
 1 files changed

// File: rtl/mac_result_fifo.sv
// mac_result_fifo: synchronous FIFO buffering accumulator results from the MAC stage.
// The upstream producer has no backpressure. A word offered while the FIFO is full,
// with no pop in the same cycle, is dropped and latches the sticky overflow flag.
// All outputs are derived from registered state only.
module mac_result_fifo #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_in,
   input  logic [WIDTH-1:0]         d_in,
   input  logic                     ready_out,
   output logic                     valid_out,
   output logic [WIDTH-1:0]         d_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_drop;

   // Status flags, handshake qualifiers and head output from registered state
   always_comb begin
      w_empty = (r_count == '0);
      w_full  = (r_count == FULL_CNT);
      w_pop   = ~w_empty & ready_out;
      // A same-cycle pop frees a slot, so a full FIFO can still accept a word
      w_push  = valid_in & (~w_full | w_pop);
      w_drop  = valid_in & w_full & ~w_pop;
   end

   // Pointer, occupancy and sticky overflow update; reset overrides any handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Storage array; not reset, and writes are suppressed while reset is asserted
   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= d_in;
   end

   // Output drive; d_out is forced to zero when empty so stale entries never show
   always_comb begin
      valid_out = ~w_empty;
      d_out     = w_empty ? '0 : r_mem[r_rd_ptr];
      count     = r_count;
      full      = w_full;
      empty     = w_empty;
      overflow  = r_overflow;
   end

endmodule
